// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing from the 50 MHz system clock.
// Produces a pixel-rate enable, DrawX/DrawY scan position, active-low syncs, blank,
// a frame strobe and a frame counter. A second copy of sync/blank is delayed by
// SYNC_DELAY pixel ticks so it lines up with the downstream ROM-lookup latency.
// Counters are 10 bits wide, so H_TOTAL and V_TOTAL must not exceed 1024.

module vga_timing_gen #(
  parameter int unsigned PIX_DIV    = 2,
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned SYNC_DELAY = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic       pix_ce,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank_n,
  output logic       hs_d,
  output logic       vs_d,
  output logic       blank_n_d,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  // Reset pattern for one delay stage: {hs, vs, blank_n}.
  localparam logic [2:0] DLY_RST = 3'b110;

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             hs_q, hs_d_nxt;
  logic             vs_q, vs_d_nxt;
  logic             blank_n_q, blank_n_nxt;
  logic             frame_start_q, frame_start_nxt;
  logic [7:0]       frame_count_q, frame_count_nxt;
  logic             h_last, v_last, wrap;

  // Pixel enable is a pure decode of the divider so it is valid straight out of reset.
  always_comb begin
    pix_ce = (div_q == DIV_LAST);
  end

  // Next-state: divider, raster counters and the sync/blank decode of the next position.
  always_comb begin
    div_d           = pix_ce ? '0 : div_q + 1'b1;
    h_last          = (x_q == H_LAST);
    v_last          = (y_q == V_LAST);
    wrap            = pix_ce & h_last & v_last;
    x_d             = x_q;
    y_d             = y_q;
    hs_d_nxt        = hs_q;
    vs_d_nxt        = vs_q;
    blank_n_nxt     = blank_n_q;
    frame_start_nxt = wrap;
    frame_count_nxt = frame_count_q + {7'd0, wrap};
    if (pix_ce) begin
      if (h_last) begin
        x_d = '0;
        y_d = v_last ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
      // Decode the position being loaded so sync/blank stay coincident with DrawX/DrawY.
      hs_d_nxt    = ~((x_d >= H_SYNC_START) && (x_d < H_SYNC_END));
      vs_d_nxt    = ~((y_d >= V_SYNC_START) && (y_d < V_SYNC_END));
      blank_n_nxt = (x_d < H_VIS_END) && (y_d < V_VIS_END);
    end
  end

  // State registers with synchronous reset; blank_n holds 0 until the first pixel tick.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      div_q         <= div_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hs_q          <= hs_d_nxt;
      vs_q          <= vs_d_nxt;
      blank_n_q     <= blank_n_nxt;
      frame_start_q <= frame_start_nxt;
      frame_count_q <= frame_count_nxt;
    end
  end

  // Drive the undelayed outputs straight from their registers.
  always_comb begin
    DrawX       = x_q;
    DrawY       = y_q;
    hs          = hs_q;
    vs          = vs_q;
    blank_n     = blank_n_q;
    frame_start = frame_start_q;
    frame_count = frame_count_q;
  end

  if (SYNC_DELAY == 0) begin : g_no_delay
    // Zero delay: the aligned copies are the raw outputs.
    always_comb begin
      hs_d      = hs_q;
      vs_d      = vs_q;
      blank_n_d = blank_n_q;
    end
  end else begin : g_delay
    logic [2:0] dly_q [SYNC_DELAY];

    // Shift register advancing one stage per pixel tick; reset flushes it to idle syncs.
    always_ff @(posedge Clk) begin
      if (Reset) begin
        for (int i = 0; i < int'(SYNC_DELAY); i++) begin
          dly_q[i] <= DLY_RST;
        end
      end else if (pix_ce) begin
        dly_q[0] <= {hs_q, vs_q, blank_n_q};
        for (int i = 1; i < int'(SYNC_DELAY); i++) begin
          dly_q[i] <= dly_q[i-1];
        end
      end
    end

    // Tap the last stage.
    always_comb begin
      hs_d      = dly_q[SYNC_DELAY-1][2];
      vs_d      = dly_q[SYNC_DELAY-1][1];
      blank_n_d = dly_q[SYNC_DELAY-1][0];
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: directed steps with a scoreboard queue of expected values.
// Four builds: default timing, zero sync delay, PIX_DIV=1, and a tiny raster for frame tests.

module tb_vga_timing_gen;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  // Default build (PIX_DIV=2, SYNC_DELAY=2)
  logic m_ce, m_hs, m_vs, m_bn, m_hsd, m_vsd, m_bnd, m_fs;
  logic [9:0] m_x, m_y;
  logic [7:0] m_fc;
  // SYNC_DELAY=0 build
  logic n_ce, n_hs, n_vs, n_bn, n_hsd, n_vsd, n_bnd, n_fs;
  logic [9:0] n_x, n_y;
  logic [7:0] n_fc;
  // PIX_DIV=1 build
  logic f_ce, f_hs, f_vs, f_bn, f_hsd, f_vsd, f_bnd, f_fs;
  logic [9:0] f_x, f_y;
  logic [7:0] f_fc;
  // Tiny raster: H 4+1+2+1=8, V 3+1+1+1=6, PIX_DIV=1, SYNC_DELAY=1
  logic s_ce, s_hs, s_vs, s_bn, s_hsd, s_vsd, s_bnd, s_fs;
  logic [9:0] s_x, s_y;
  logic [7:0] s_fc;

  vga_timing_gen u_main (
    .Clk(Clk), .Reset(Reset), .pix_ce(m_ce), .DrawX(m_x), .DrawY(m_y), .hs(m_hs), .vs(m_vs),
    .blank_n(m_bn), .hs_d(m_hsd), .vs_d(m_vsd), .blank_n_d(m_bnd), .frame_start(m_fs),
    .frame_count(m_fc)
  );

  vga_timing_gen #(.SYNC_DELAY(0)) u_nodly (
    .Clk(Clk), .Reset(Reset), .pix_ce(n_ce), .DrawX(n_x), .DrawY(n_y), .hs(n_hs), .vs(n_vs),
    .blank_n(n_bn), .hs_d(n_hsd), .vs_d(n_vsd), .blank_n_d(n_bnd), .frame_start(n_fs),
    .frame_count(n_fc)
  );

  vga_timing_gen #(.PIX_DIV(1)) u_fast (
    .Clk(Clk), .Reset(Reset), .pix_ce(f_ce), .DrawX(f_x), .DrawY(f_y), .hs(f_hs), .vs(f_vs),
    .blank_n(f_bn), .hs_d(f_hsd), .vs_d(f_vsd), .blank_n_d(f_bnd), .frame_start(f_fs),
    .frame_count(f_fc)
  );

  vga_timing_gen #(
    .PIX_DIV(1), .H_VISIBLE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VISIBLE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_DELAY(1)
  ) u_small (
    .Clk(Clk), .Reset(Reset), .pix_ce(s_ce), .DrawX(s_x), .DrawY(s_y), .hs(s_hs), .vs(s_vs),
    .blank_n(s_bn), .hs_d(s_hsd), .vs_d(s_vsd), .blank_n_d(s_bnd), .frame_start(s_fs),
    .frame_count(s_fc)
  );

  typedef struct {
    string       tag;
    int unsigned val;
  } exp_t;

  exp_t sb_q[$];
  int unsigned passes = 0;
  int unsigned total  = 0;

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic expect_val(input string tag, input int unsigned v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic compare(input int unsigned obs);
    exp_t e;
    total++;
    if (sb_q.size() == 0) begin
      $error("FAIL sb_empty: observed %0d with no expected value queued", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) begin
        passes++;
      end else begin
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int hs_first, hsd_first, hs_cnt, bn_err, bnd_err, nd_err, cnt;
    int xy_err, vs_err, hs_err, sb_err, fs_err, fc_err, vs_low;
    int unsigned sx, sy, ebn;

    // ---- Step 1: reset values and release timing ----
    Reset = 1'b1;
    tick(3);
    expect_val("rst_x", 0);       expect_val("rst_y", 0);
    expect_val("rst_hs", 1);      expect_val("rst_vs", 1);
    expect_val("rst_bn", 0);      expect_val("rst_hsd", 1);
    expect_val("rst_vsd", 1);     expect_val("rst_bnd", 0);
    expect_val("rst_fs", 0);      expect_val("rst_fc", 0);
    expect_val("rst_ce", 0);
    compare(m_x);   compare(m_y);   compare(m_hs);  compare(m_vs);
    compare(m_bn);  compare(m_hsd); compare(m_vsd); compare(m_bnd);
    compare(m_fs);  compare(m_fc);  compare(m_ce);

    Reset = 1'b0;
    expect_val("rel_ce0", 0);     expect_val("fast_ce", 1);
    compare(m_ce);  compare(f_ce);
    tick(1);
    expect_val("rel_ce1", 1);     expect_val("rel_x_before", 0);
    expect_val("rel_bn_before", 0); expect_val("fast_x1", 1);
    compare(m_ce);  compare(m_x);  compare(m_bn);  compare(f_x);
    tick(1);
    expect_val("rel_x_after", 1); expect_val("rel_bn_after", 1);
    expect_val("rel_ce2", 0);     expect_val("fast_x2", 2);
    compare(m_x);   compare(m_bn); compare(m_ce);  compare(f_x);

    // ---- Step 3/5: scan line 0 ----
    hs_first = -1; hsd_first = -1; hs_cnt = 0; bn_err = 0; bnd_err = 0; nd_err = 0;
    for (int i = 0; i < 1600; i++) begin
      tick(1);
      if (m_y == 10'd0) begin
        if (m_hs == 1'b0 && hs_first < 0) hs_first = int'(m_x);
        if (m_hsd == 1'b0 && hsd_first < 0) hsd_first = int'(m_x);
        if (m_hs == 1'b0 && m_ce == 1'b1) hs_cnt++;
        if (m_bn !== (m_x < 10'd640)) bn_err++;
        if (m_bnd !== (m_x >= 10'd3 && m_x <= 10'd641)) bnd_err++;
      end
      if (n_hsd !== n_hs || n_vsd !== n_vs || n_bnd !== n_bn) nd_err++;
      if (n_hs !== m_hs || n_bn !== m_bn || n_x !== m_x) nd_err++;
    end
    expect_val("hs_first_x", 656);  expect_val("hs_low_ticks", 96);
    expect_val("bn_line0_err", 0);  expect_val("hsd_first_x", 658);
    expect_val("bnd_lag_err", 0);   expect_val("nodly_err", 0);
    compare(hs_first); compare(hs_cnt); compare(bn_err);
    compare(hsd_first); compare(bnd_err); compare(nd_err);

    // ---- Step 2: line wrap at (799,10) ----
    cnt = 0;
    while (!(m_x == 10'd799 && m_y == 10'd10) && cnt < 20000) begin
      tick(1);
      cnt++;
    end
    expect_val("reach_799_10", 1);
    compare((cnt < 20000) ? 1 : 0);
    tick(2);
    expect_val("wrap_x", 0);  expect_val("wrap_y", 11);
    expect_val("wrap_bn", 1); expect_val("wrap_hs", 1);
    compare(m_x); compare(m_y); compare(m_bn); compare(m_hs);

    // ---- Step 6: reset mid-frame ----
    cnt = 0;
    while (m_x != 10'd300 && cnt < 2000) begin
      tick(1);
      cnt++;
    end
    expect_val("reach_x300", 1);  expect_val("pre_rst_bnd", 1);
    compare((cnt < 2000) ? 1 : 0); compare(m_bnd);
    Reset = 1'b1;
    tick(1);
    expect_val("mid_x", 0);    expect_val("mid_y", 0);
    expect_val("mid_hs", 1);   expect_val("mid_vs", 1);
    expect_val("mid_bn", 0);   expect_val("mid_hsd", 1);
    expect_val("mid_bnd", 0);  expect_val("mid_fc_small", 0);
    expect_val("mid_fs_small", 0);
    compare(m_x);  compare(m_y);  compare(m_hs);  compare(m_vs);
    compare(m_bn); compare(m_hsd); compare(m_bnd); compare(s_fc); compare(s_fs);
    tick(1);
    Reset = 1'b0;

    // ---- Step 4: frame timing on the tiny raster (48 Clk per frame) ----
    xy_err = 0; vs_err = 0; hs_err = 0; sb_err = 0; fs_err = 0; fc_err = 0; vs_low = 0;
    for (int n = 0; n <= 48 * 256 + 1; n++) begin
      if (n > 0) tick(1);
      sx = n % 8;
      sy = (n / 8) % 6;
      if (n < 48) begin
        if (s_vs == 1'b0) vs_low++;
      end
      if (int'(s_x) != int'(sx) || int'(s_y) != int'(sy)) xy_err++;
      if (s_vs !== ((sy == 4) ? 1'b0 : 1'b1)) vs_err++;
      if (s_hs !== ((sx == 5 || sx == 6) ? 1'b0 : 1'b1)) hs_err++;
      ebn = (n == 0) ? 0 : ((sx < 4 && sy < 3) ? 1 : 0);
      if (int'(s_bn) != int'(ebn)) sb_err++;
      if (s_fs !== ((n >= 48 && n % 48 == 0) ? 1'b1 : 1'b0)) fs_err++;
      if (int'(s_fc) != (n / 48) % 256) fc_err++;
      if (n == 47) begin
        expect_val("fs_before_wrap", 0); expect_val("fc_before_wrap", 0);
        compare(s_fs); compare(s_fc);
      end
      if (n == 48) begin
        expect_val("fs_at_wrap", 1); expect_val("fc_after_1", 1);
        compare(s_fs); compare(s_fc);
      end
      if (n == 49) begin
        expect_val("fs_one_clk", 0);
        compare(s_fs);
      end
      if (n == 48 * 255) begin
        expect_val("fc_255", 255);
        compare(s_fc);
      end
      if (n == 48 * 256) begin
        expect_val("fc_wrap_0", 0); expect_val("fs_wrap_256", 1);
        compare(s_fc); compare(s_fs);
      end
    end
    expect_val("vs_low_ticks", 8);  expect_val("small_xy_err", 0);
    expect_val("small_vs_err", 0);  expect_val("small_hs_err", 0);
    expect_val("small_bn_err", 0);  expect_val("small_fs_err", 0);
    expect_val("small_fc_err", 0);
    compare(vs_low); compare(xy_err); compare(vs_err); compare(hs_err);
    compare(sb_err); compare(fs_err); compare(fc_err);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
